// File: rtl/fetch_align_buffer_if.sv
// Fetch/decode side bundle of the fetch align buffer: enqueue slice, dequeue
// request, head window and occupancy/error status.
interface fetch_align_buffer_if #(
    parameter int IN_WIDTH  = 512,
    parameter int OUT_WIDTH = 120
);
    logic                 flush;
    logic                 enq;
    logic [31:0]          enq_cnt;
    logic [0:IN_WIDTH-1]  enq_data;
    logic                 deq;
    logic [31:0]          deq_cnt;
    logic [0:OUT_WIDTH-1] deq_data;
    logic [31:0]          used_cnt;
    logic [31:0]          empty_cnt;
    logic                 ovf_err;
    logic                 unf_err;

    modport master (
        output flush, enq, enq_cnt, enq_data, deq, deq_cnt,
        input  deq_data, used_cnt, empty_cnt, ovf_err, unf_err
    );

    modport slave (
        input  flush, enq, enq_cnt, enq_data, deq, deq_cnt,
        output deq_data, used_cnt, empty_cnt, ovf_err, unf_err
    );
endinterface

// File: rtl/fetch_align_buffer.sv
// Byte-granular circular buffer: fetch appends left-aligned slices at the tail,
// decode always sees the oldest OUT_WIDTH bits at the head and pops what it used.
module fetch_align_buffer #(
    parameter int IN_WIDTH  = 512,
    parameter int OUT_WIDTH = 120,
    parameter int DEPTH     = 2048
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_align_buffer_if.slave   bus
);
    localparam int NBYTES    = DEPTH / 8;
    localparam int PW        = $clog2(NBYTES);
    localparam int IN_BYTES  = IN_WIDTH / 8;
    localparam int OUT_BYTES = OUT_WIDTH / 8;

    logic [7:0]           r_mem [NBYTES];
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [31:0]          r_used;
    logic                 r_ovf;
    logic                 r_unf;

    logic [31:0]          w_empty;
    logic                 w_deq_ok;
    logic                 w_deq_bad;
    logic                 w_enq_ok;
    logic                 w_enq_bad;
    logic [31:0]          w_deq_amt;
    logic [31:0]          w_enq_amt;
    logic [31:0]          w_enq_bytes;
    logic [31:0]          w_used_bytes;
    logic [0:OUT_WIDTH-1] w_deq_data;

    assign w_empty      = 32'(DEPTH) - r_used;
    assign w_enq_bytes  = {3'b000, bus.enq_cnt[31:3]};
    assign w_used_bytes = {3'b000, r_used[31:3]};

    // Both checks use pre-edge occupancy, so a same-cycle pop never makes room.
    assign w_deq_ok  = bus.deq && !bus.flush && (bus.deq_cnt <= r_used);
    assign w_deq_bad = bus.deq && !bus.flush && (bus.deq_cnt > r_used);
    assign w_enq_ok  = bus.enq && !bus.flush && (bus.enq_cnt <= w_empty);
    assign w_enq_bad = bus.enq && !bus.flush && (bus.enq_cnt > w_empty);

    assign w_deq_amt = w_deq_ok ? bus.deq_cnt : 32'd0;
    assign w_enq_amt = w_enq_ok ? bus.enq_cnt : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_used <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else if (bus.flush) begin
            r_head <= r_tail;
            r_used <= '0;
        end else begin
            r_head <= r_head + w_deq_amt[PW+2:3];
            r_tail <= r_tail + w_enq_amt[PW+2:3];
            r_used <= r_used - w_deq_amt + w_enq_amt;
            if (w_deq_bad) r_ovf <= r_ovf;
            if (w_deq_bad) r_unf <= 1'b1;
            if (w_enq_bad) r_ovf <= 1'b1;
        end
    end

    // Storage is never cleared; stale bytes are hidden by the occupancy mask below.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_BYTES; i++) begin
            if (w_enq_ok && (32'(i) < w_enq_bytes))
                r_mem[r_tail + PW'(i)] <= bus.enq_data[8*i +: 8];
        end
    end

    always_comb begin
        w_deq_data = '0;
        for (int j = 0; j < OUT_BYTES; j++) begin
            if (32'(j) < w_used_bytes)
                w_deq_data[8*j +: 8] = r_mem[r_head + PW'(j)];
        end
    end

    assign bus.deq_data  = w_deq_data;
    assign bus.used_cnt  = r_used;
    assign bus.empty_cnt = w_empty;
    assign bus.ovf_err   = r_ovf;
    assign bus.unf_err   = r_unf;
endmodule
